// File: rtl/soc_system_print_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_print_ctrl
// Description : Debounced print-request button with an Avalon-MM register
//               file and a level interrupt. The optional press timestamp is
//               built only when PRINT_CTRL_TIMESTAMP_EN is defined.
// Revision    : 1.0
// ============================================================================
module soc_system_print_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_port,
    output logic        irq
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'd0,
        CONFIRM_HIGH = 2'd1,
        IDLE_HIGH    = 2'd2,
        CONFIRM_LOW  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        rise;
    logic        fall;
    logic        stable;

    logic        sync_ff1;
    logic        sync_in;
    logic        enable;
    logic        irq_en;
    logic        press_pending;
    logic        release_pending;
    logic [15:0] press_count;
    logic [31:0] ts_word;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        unused_wdata;

    assign unused_wdata = ^writedata[31:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff1 <= 1'b0;
            sync_in  <= 1'b0;
        end else begin
            sync_ff1 <= in_port;
            sync_in  <= sync_ff1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A reverting sample inside a CONFIRM state drops back without an edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise    = 1'b0;
        fall    = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE_LOW: begin
                    if (sync_in) begin
                        state_d = CONFIRM_HIGH;
                        cnt_d   = '0;
                    end
                end
                CONFIRM_HIGH: begin
                    if (!sync_in) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_HIGH;
                        cnt_d   = '0;
                        rise    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_in) begin
                        state_d = CONFIRM_LOW;
                        cnt_d   = '0;
                    end
                end
                CONFIRM_LOW: begin
                    if (sync_in) begin
                        state_d = IDLE_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                        fall    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign stable  = (state_q == IDLE_HIGH) || (state_q == CONFIRM_LOW);
    assign wr_ctrl = write && (address == 2'd1);
    assign wr_stat = write && (address == 2'd2);

    // A new edge beats a same-cycle clear; count clear plus press yields 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable          <= 1'b1;
            irq_en          <= 1'b0;
            press_pending   <= 1'b0;
            release_pending <= 1'b0;
            press_count     <= '0;
        end else begin
            if (wr_ctrl) begin
                enable <= writedata[1];
                irq_en <= writedata[0];
            end
            press_pending   <= rise | (press_pending & ~(wr_stat & writedata[0]));
            release_pending <= fall | (release_pending & ~(wr_stat & writedata[1]));
            if (wr_stat && writedata[2]) begin
                press_count <= rise ? 16'd1 : 16'd0;
            end else if (rise && (press_count != 16'hFFFF)) begin
                press_count <= press_count + 16'd1;
            end
        end
    end

`ifdef PRINT_CTRL_TIMESTAMP_EN
    logic [31:0] ts_counter;
    logic [31:0] press_ts;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_counter <= '0;
            press_ts   <= '0;
        end else begin
            ts_counter <= ts_counter + 32'd1;
            if (rise) begin
                press_ts <= ts_counter;
            end
        end
    end

    assign ts_word = press_ts;
`else
    assign ts_word = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= {30'b0, sync_in, stable};
                2'd1:    readdata <= {30'b0, enable, irq_en};
                2'd2:    readdata <= {press_count, 14'b0, release_pending, press_pending};
                default: readdata <= ts_word;
            endcase
        end
    end

    assign irq = irq_en & (press_pending | release_pending);

endmodule
`default_nettype wire

// File: tb/tb_soc_system_print_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_system_print_ctrl
// Description : Directed plus randomized bench for soc_system_print_ctrl with
//               a run-length debounce reference model.
// Revision    : 1.0
// ============================================================================
module tb_soc_system_print_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        in_port;
    logic        irq;

    int tests = 0;
    int fails = 0;

    soc_system_print_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted after N+1 consecutive synchronized
    // samples that differ from the current stable level.
    logic        m_s1, m_s2, m_stable, m_en, m_irqen, m_pp, m_rp;
    logic        m_force_sat = 1'b0;
    logic [7:0]  m_run;
    logic [15:0] m_cnt;
    logic [31:0] m_rd, m_cyc, m_ts, m_tsword;
    logic        m_diff, m_acc, m_press, m_rel, m_w1, m_w2, m_irq;

    assign m_diff  = (m_s2 != m_stable);
    assign m_acc   = m_en && m_diff && (m_run == 8'(N));
    assign m_press = m_acc && !m_stable;
    assign m_rel   = m_acc && m_stable;
    assign m_w1    = write && (address == 2'd1);
    assign m_w2    = write && (address == 2'd2);
    assign m_irq   = m_irqen && (m_pp || m_rp);
`ifdef PRINT_CTRL_TIMESTAMP_EN
    assign m_tsword = m_ts;
`else
    assign m_tsword = 32'd0;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_stable <= 1'b0; m_run <= 8'd0;
            m_en <= 1'b1; m_irqen <= 1'b0; m_pp <= 1'b0; m_rp <= 1'b0;
            m_cnt <= 16'd0; m_rd <= 32'd0; m_cyc <= 32'd0; m_ts <= 32'd0;
        end else begin
            m_s1  <= in_port;
            m_s2  <= m_s1;
            m_cyc <= m_cyc + 32'd1;
            if (m_en) begin
                if (!m_diff) m_run <= 8'd0;
                else if (m_acc) begin
                    m_run    <= 8'd0;
                    m_stable <= !m_stable;
                end else m_run <= m_run + 8'd1;
            end else if (m_run != 8'd0) begin
                m_run <= 8'd1;
            end
            if (m_w1) begin
                m_en    <= writedata[1];
                m_irqen <= writedata[0];
            end
            m_pp <= m_press || (m_pp && !(m_w2 && writedata[0]));
            m_rp <= m_rel || (m_rp && !(m_w2 && writedata[1]));
            if (m_force_sat) m_cnt <= 16'hFFFF;
            else if (m_w2 && writedata[2]) m_cnt <= m_press ? 16'd1 : 16'd0;
            else if (m_press && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            if (m_press) m_ts <= m_cyc;
            case (address)
                2'd0:    m_rd <= {30'b0, m_s2, m_stable};
                2'd1:    m_rd <= {30'b0, m_en, m_irqen};
                2'd2:    m_rd <= {m_cnt, 14'b0, m_rp, m_pp};
                default: m_rd <= m_tsword;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            tick();
            chk("readdata", readdata, m_rd);
            chk("irq", {31'b0, irq}, {31'b0, m_irq});
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        cyc(1);
        write     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hold;
        logic found;
        reset_n = 1'b0; in_port = 1'b0; address = 2'd0; write = 1'b0; writedata = 32'd0;
        repeat (2) tick();
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_irq", {31'b0, irq}, 32'd0);
        reset_n = 1'b1;
        cyc(2);

        // Press acceptance latency: stable rises 6 edges after first sampling edge
        in_port = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("latency_addr0", readdata, {30'b0, (k >= 3), (k >= 8)});
        end
        address = 2'd2;
        tick();
        chk("first_press_addr2", readdata, 32'h0001_0001);

        // Glitch of 3 cycles is rejected
        in_port = 1'b0;
        cyc(12);
        wr(2'd2, 32'h7);
        cyc(2);
        in_port = 1'b1;
        cyc(3);
        in_port = 1'b0;
        cyc(10);
        address = 2'd0;
        tick();
        chk("glitch_stable", {31'b0, readdata[0]}, 32'd0);
        address = 2'd2;
        tick();
        chk("glitch_addr2", readdata, 32'd0);

        // Interrupt set / clear / clear racing a new press
        wr(2'd1, 32'h3);
        in_port = 1'b1;
        cyc(10);
        chk("irq_on_press", {31'b0, irq}, 32'd1);
        wr(2'd2, 32'h1);
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        in_port = 1'b0;
        cyc(12);
        wr(2'd2, 32'h3);
        in_port = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_acc) found = 1'b1;
            else cyc(1);
        end
        chk("accept_wait", {31'b0, found}, 32'd1);
        wr(2'd2, 32'h1);
        chk("set_wins_irq", {31'b0, irq}, 32'd1);
        tick();
        chk("set_wins_pending", {31'b0, readdata[0]}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            in_port = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 9));
            for (int j = 0; j < hold; j++) begin
                address = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) begin
                    write     = 1'b1;
                    writedata = $urandom;
                    writedata[1] = ($urandom_range(0, 3) != 0);
                end else begin
                    write = 1'b0;
                end
                cyc(1);
            end
        end
        write = 1'b0;
        wr(2'd1, 32'h3);

        // Saturation of press_count
        in_port = 1'b0;
        cyc(12);
        wr(2'd2, 32'h3);
        force dut.press_count = 16'hFFFF;
        m_force_sat = 1'b1;
        tick();
        release dut.press_count;
        m_force_sat = 1'b0;
        address = 2'd2;
        cyc(1);
        chk("sat_preset", {16'b0, readdata[31:16]}, 32'h0000_FFFF);
        in_port = 1'b1;
        cyc(12);
        chk("sat_hold", readdata, 32'hFFFF_0001);
        wr(2'd2, 32'h4);
        cyc(1);
        chk("count_clear", readdata, 32'h0000_0001);

        // Disabled debounce ignores toggles, then one press on enable
        in_port = 1'b0;
        cyc(12);
        wr(2'd2, 32'h7);
        wr(2'd1, 32'h1);
        for (int k = 0; k < 10; k++) begin
            in_port = ~in_port;
            cyc(6);
        end
        address = 2'd2;
        cyc(1);
        chk("disabled_addr2", readdata, 32'd0);
        in_port = 1'b1;
        cyc(4);
        wr(2'd1, 32'h3);
        address = 2'd2;
        cyc(12);
        chk("enable_single_press", readdata, 32'h0001_0001);

        // Reset in the middle of a confirm window
        in_port = 1'b0;
        cyc(12);
        in_port = 1'b1;
        cyc(4);
        reset_n = 1'b0;
        #1;
        chk("midreset_readdata", readdata, 32'd0);
        chk("midreset_irq", {31'b0, irq}, 32'd0);
        tick();
        reset_n = 1'b1;
        address = 2'd2;
        cyc(12);
        chk("requalify_press", readdata, 32'h0001_0001);

        // Timestamp register
        address = 2'd3;
        cyc(1);
`ifdef PRINT_CTRL_TIMESTAMP_EN
        chk("timestamp", readdata, m_ts);
`else
        chk("timestamp_absent", readdata, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_system_print_ctrl.md
SOC_SYSTEM_PRINT_CTRL -- requirements
Module: soc_system_print_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set consecutive clk cycles a new input level must hold before acceptance (1 ms at 50 MHz); legal range 2..65535.
REQ-002 clk  input  1  system clock; all logic SHALL be rising-edge clk.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 address  input  2  Avalon-MM word address.
REQ-005 write  input  1  Avalon-MM write strobe, active-high, single cycle.
REQ-006 writedata  input  32  Avalon-MM write data.
REQ-007 readdata  output  32  Avalon-MM read data, registered.
REQ-008 in_port  input  1  raw asynchronous print-request line.
REQ-009 irq  output  1  level interrupt to HPS, active-high.

Function
REQ-010 in_port SHALL pass a 2-flop synchronizer; sync_in is the second flop output.
REQ-011 Debounce FSM SHALL have states IDLE_LOW, CONFIRM_HIGH, IDLE_HIGH, CONFIRM_LOW; stable level = 1 in IDLE_HIGH/CONFIRM_LOW, else 0.
REQ-012 IDLE_LOW->CONFIRM_HIGH when sync_in=1; IDLE_HIGH->CONFIRM_LOW when sync_in=0; counter cleared on entry.
REQ-013 In CONFIRM_x, counter SHALL increment each cycle sync_in equals new level; when counter reaches DEBOUNCE_CYCLES-1 with sync_in still equal, FSM SHALL move to IDLE_x of new level next edge.
REQ-014 In CONFIRM_x, any cycle sync_in returns to old level SHALL return FSM to prior IDLE state, counter cleared, no edge generated (glitch rejection).
REQ-015 Accepted 0->1 transition SHALL set press_pending and increment press_count; accepted 1->0 SHALL set release_pending.
REQ-016 press_count SHALL be 16 bits, saturating at 0xFFFF (no wrap).
REQ-017 Register map (read): addr0 = {30'b0, sync_in, stable}; addr1 = {30'b0, enable, irq_en}; addr2 = {press_count, 14'b0, release_pending, press_pending}; addr3 = timestamp per REQ-026/027.
REQ-018 readdata SHALL update every clk from address (no read strobe), one-cycle latency.
REQ-019 Writes: addr1 loads writedata[1:0] into {enable, irq_en}; addr2 writedata[0]=1 clears press_pending, [1]=1 clears release_pending, [2]=1 clears press_count; writes to addr0/addr3 ignored.
REQ-020 Same-cycle clear and new edge on a pending bit: set SHALL win; same-cycle count clear and increment: result SHALL be 1.
REQ-021 enable=0 SHALL freeze FSM state and hold counter at zero; no edges, no count change; sync flops keep running.
REQ-022 irq SHALL equal irq_en & (press_pending | release_pending), driven from registers.

Reset
REQ-023 On reset_n=0, asynchronously: sync flops 0, FSM IDLE_LOW, counter 0, pending bits 0, press_count 0, irq_en 0, enable 1, readdata 0, timestamp regs 0; irq therefore 0.
REQ-024 Reset asserted mid-CONFIRM SHALL discard the pending transition; after release a held-high in_port SHALL be re-qualified from IDLE_LOW and produce one press edge.
REQ-025 No output SHALL depend on reset deassertion timing beyond the first clk edge after release.

Configuration
REQ-026 Macro PRINT_CTRL_TIMESTAMP_EN defined: 32-bit free-running cycle counter (wraps at 0xFFFFFFFF to 0), latched into press_ts on each accepted press edge; addr3 reads press_ts.
REQ-027 Macro undefined: counter and press_ts not built; addr3 reads 0; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, in_port 0->1 held -> addr0 bit0=1 exactly 6 clk after first sampling edge; addr2 = 0x00010001.
REQ-029 in_port high 3 cycles then low -> stable stays 0, press_pending 0, press_count 0.
REQ-030 irq_en=1, press accepted -> irq=1; write addr2 0x1 -> irq=0 next clk; clear coincident with new press edge -> press_pending stays 1.
REQ-031 press_count preset to 0xFFFF via 65535 presses (or forced) plus one press -> count stays 0xFFFF; write addr2 0x4 -> 0.
REQ-032 enable=0, toggle in_port 10 times -> no pending bits, count unchanged; enable=1 with in_port high -> single press.
REQ-033 With PRINT_CTRL_TIMESTAMP_EN, press accepted at cycle N -> addr3 = N relative to reset release; without macro addr3 = 0.
